cpu15_run_ctrl: RTL and testbench

- Execution controller that sequences the cpu15 core. It owns the core's instruction-advance enable and provides run, halt and single-step control from a command handshake.
- It also provides a PC breakpoint, a retired-instruction counter and an optional instruction-limit auto-halt.
- It sits between the simulation bench or debug host and cpu15. cpu15 executes exactly one instruction on each CLK rising edge where CPU_EN=1, and holds all state otherwise.

---
 rtl/cpu15_run_ctrl_if.sv | 23 ++
 rtl/cpu15_run_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_cpu15_run_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu15_run_ctrl_if.sv
// Command handshake between a debug host (or bench) and the cpu15 run
// controller. A command transfers on a cycle where cmd_valid && cmd_ready.
interface cpu15_run_ctrl_if;

  logic       cmd_valid;  // command present
  logic [1:0] cmd;        // 00 NOP, 01 RUN, 10 HALT, 11 STEP
  logic       cmd_ready;  // controller can accept a command this cycle

  // Host side: presents commands, observes readiness.
  modport master (
    output cmd_valid,
    output cmd,
    input  cmd_ready
  );

  // Controller side: consumes commands, reports readiness.
  modport slave (
    input  cmd_valid,
    input  cmd,
    output cmd_ready
  );

endinterface : cpu15_run_ctrl_if

// File: rtl/cpu15_run_ctrl.sv
// cpu15 execution controller.
// Owns the core's instruction-advance enable and sequences it through
// HALT / RUN / single-STEP from a command handshake. Also provides a PC
// breakpoint, a saturating retired-instruction counter and an optional
// instruction-limit auto-halt. The core executes one instruction on every
// rising clk edge where cpu_en_o is high.
module cpu15_run_ctrl #(
  parameter int unsigned CNT_W     = 16,   // width of the instruction counter
  parameter int unsigned RUN_LIMIT = 0,    // auto-halt after this many instructions, 0 = off
  parameter bit          START_RUN = 1'b1  // 1: free-run out of reset, 0: come up halted
) (
  input  logic               clk,
  input  logic               rst_n,
  cpu15_run_ctrl_if.slave    cmd_if,
  input  logic               bp_en_i,
  input  logic [7:0]         bp_addr_i,
  input  logic [7:0]         pc_i,
  input  logic               clr_cnt_i,
  output logic               cpu_en_o,
  output logic               running_o,
  output logic               bp_hit_o,
  output logic               limit_hit_o,
  output logic [CNT_W-1:0]   instr_cnt_o
);

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_RUN  = 2'b01,
    CMD_HALT = 2'b10,
    CMD_STEP = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  localparam state_e          RESET_STATE = START_RUN ? ST_RUN : ST_HALT;
  localparam bit              LIMIT_ON    = (RUN_LIMIT != 0);
  localparam logic [CNT_W-1:0] LIMIT_V    = CNT_W'(RUN_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_M1   = CNT_W'(RUN_LIMIT - 1);

  state_e           state_q, state_d;
  logic             skip_q, skip_d;
  logic             bp_hit_q, bp_hit_d;
  logic             limit_hit_q, limit_hit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  cmd_e cmd;
  logic cmd_ready;
  logic cmd_acc;
  logic halt_cmd;
  logic go_cmd;
  logic step_cmd;
  logic brk;
  logic at_limit;
  logic last_instr;
  logic cpu_en;

  // ---------------------------------------------------------------------------
  // Command decode and trap conditions
  // ---------------------------------------------------------------------------

  // Readiness depends only on registered state, so there is no path from the
  // command inputs back to cmd_ready.
  assign cmd_ready = (state_q != ST_STEP);
  assign cmd       = cmd_e'(cmd_if.cmd);
  assign cmd_acc   = cmd_if.cmd_valid && cmd_ready;
  assign halt_cmd  = cmd_acc && (cmd == CMD_HALT);
  assign step_cmd  = cmd_acc && (cmd == CMD_STEP);
  assign go_cmd    = cmd_acc && ((cmd == CMD_RUN) || (cmd == CMD_STEP));

  // skip masks the breakpoint for the first instruction after a resume, so
  // restarting from the breakpoint address does not immediately re-trap.
  assign brk = bp_en_i && (pc_i == bp_addr_i) && !skip_q;

  // at_limit: the limit is exhausted and the core must stay parked until the
  // counter is cleared. last_instr: the enabled instruction this cycle is
  // the final one the limit allows.
  assign at_limit   = LIMIT_ON && (cnt_q >= LIMIT_V);
  assign last_instr = LIMIT_ON && (cnt_q == LIMIT_M1);

  // ---------------------------------------------------------------------------
  // Run-control FSM: next state, sticky flags and the core enable
  // ---------------------------------------------------------------------------

  // Next-state and core-enable decode for the HALT/RUN/STEP sequencer.
  always_comb begin
    // NOTE: every signal is given a default before the case so no path
    // leaves it unassigned; an unassigned path would infer a latch.
    state_d     = state_q;
    skip_d      = skip_q;
    bp_hit_d    = bp_hit_q;
    limit_hit_d = limit_hit_q;
    cpu_en      = 1'b0;

    unique case (state_q)
      ST_HALT: begin
        if (go_cmd) begin
          bp_hit_d = 1'b0;
          if (at_limit) begin
            // Limit exhausted: acknowledge the command but stay parked.
            limit_hit_d = 1'b1;
          end else begin
            limit_hit_d = 1'b0;
            skip_d      = 1'b1;
            state_d     = step_cmd ? ST_STEP : ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (halt_cmd) begin
          // An explicit halt outranks a breakpoint and does not flag it.
          state_d = ST_HALT;
        end else if (brk) begin
          // Stop in front of the breakpoint instruction; it is not executed.
          state_d  = ST_HALT;
          bp_hit_d = 1'b1;
        end else begin
          cpu_en = 1'b1;
          if (last_instr) begin
            state_d     = ST_HALT;
            limit_hit_d = 1'b1;
          end
        end
      end

      ST_STEP: begin
        // Exactly one instruction, no breakpoint evaluation, then park.
        cpu_en  = 1'b1;
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_HALT;
      end
    endcase

    if (cpu_en) begin
      skip_d = 1'b0;
    end
  end

  // Retired-instruction counter: clear wins, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt_i) begin
      cnt_d = '0;
    end else if (cpu_en && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and flag registers with asynchronous reset to the power-up state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers use non-blocking assignment so every flop samples the
    // pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      skip_q      <= 1'b1;
      bp_hit_q    <= 1'b0;
      limit_hit_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      bp_hit_q    <= bp_hit_d;
      limit_hit_q <= limit_hit_d;
      cnt_q       <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------

  assign cmd_if.cmd_ready = cmd_ready;
  assign cpu_en_o         = cpu_en;
  assign running_o        = (state_q == ST_RUN);
  assign bp_hit_o         = bp_hit_q;
  assign limit_hit_o      = limit_hit_q;
  assign instr_cnt_o      = cnt_q;

endmodule : cpu15_run_ctrl

// File: tb/tb_cpu15_run_ctrl.sv
// Self-checking bench for cpu15_run_ctrl. Three configurations are built:
//   a: free-running out of reset, no limit, 16-bit counter
//   b: halted out of reset, RUN_LIMIT=4, 16-bit counter
//   d: free-running out of reset, no limit, 4-bit counter
// Only the configuration under test is out of reset; the others share the
// stimulus but are held in reset. Each table row gives one cycle of inputs
// and the outputs expected in that cycle; rows are queued when driven and
// compared on the following falling edge.
module tb_cpu15_run_ctrl;

  localparam logic [1:0] C_NOP  = 2'd0;
  localparam logic [1:0] C_RUN  = 2'd1;
  localparam logic [1:0] C_HALT = 2'd2;
  localparam logic [1:0] C_STEP = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rst_d;
  logic       cv;
  logic [1:0] cmd;
  logic       bp_en;
  logic [7:0] bp_addr;
  logic [7:0] pc;
  logic       clr;
  int         sel;

  cpu15_run_ctrl_if if_a ();
  cpu15_run_ctrl_if if_b ();
  cpu15_run_ctrl_if if_d ();

  assign if_a.cmd_valid = cv;
  assign if_a.cmd       = cmd;
  assign if_b.cmd_valid = cv;
  assign if_b.cmd       = cmd;
  assign if_d.cmd_valid = cv;
  assign if_d.cmd       = cmd;

  logic        en_a, run_a, bp_a, lim_a;
  logic        en_b, run_b, bp_b, lim_b;
  logic        en_d, run_d, bp_d, lim_d;
  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_d;

  cpu15_run_ctrl #(.CNT_W(16), .RUN_LIMIT(0), .START_RUN(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_a), .cmd_if(if_a.slave),
    .bp_en_i(bp_en), .bp_addr_i(bp_addr), .pc_i(pc), .clr_cnt_i(clr),
    .cpu_en_o(en_a), .running_o(run_a), .bp_hit_o(bp_a),
    .limit_hit_o(lim_a), .instr_cnt_o(cnt_a)
  );

  cpu15_run_ctrl #(.CNT_W(16), .RUN_LIMIT(4), .START_RUN(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_b), .cmd_if(if_b.slave),
    .bp_en_i(bp_en), .bp_addr_i(bp_addr), .pc_i(pc), .clr_cnt_i(clr),
    .cpu_en_o(en_b), .running_o(run_b), .bp_hit_o(bp_b),
    .limit_hit_o(lim_b), .instr_cnt_o(cnt_b)
  );

  cpu15_run_ctrl #(.CNT_W(4), .RUN_LIMIT(0), .START_RUN(1'b1)) u_dut_d (
    .clk(clk), .rst_n(rst_d), .cmd_if(if_d.slave),
    .bp_en_i(bp_en), .bp_addr_i(bp_addr), .pc_i(pc), .clr_cnt_i(clr),
    .cpu_en_o(en_d), .running_o(run_d), .bp_hit_o(bp_d),
    .limit_hit_o(lim_d), .instr_cnt_o(cnt_d)
  );

  // Observed outputs of the configuration under test.
  logic        o_en, o_rdy, o_run, o_bp, o_lim;
  logic [15:0] o_cnt;

  always_comb begin
    o_en  = en_a;
    o_rdy = if_a.cmd_ready;
    o_run = run_a;
    o_bp  = bp_a;
    o_lim = lim_a;
    o_cnt = cnt_a;
    case (sel)
      1: begin
        o_en = en_b; o_rdy = if_b.cmd_ready; o_run = run_b;
        o_bp = bp_b; o_lim = lim_b; o_cnt = cnt_b;
      end
      2: begin
        o_en = en_d; o_rdy = if_d.cmd_ready; o_run = run_d;
        o_bp = bp_d; o_lim = lim_d; o_cnt = {12'd0, cnt_d};
      end
      default: ;
    endcase
  end

  typedef struct {
    logic        cv;
    logic [1:0]  cmd;
    logic        bp_en;
    logic [7:0]  bp_addr;
    logic [7:0]  pc;
    logic        clr;
    logic        e_en;
    logic        e_rdy;
    logic        e_run;
    logic        e_bp;
    logic        e_lim;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl_a[$];
  vec_t tbl_b[$];
  vec_t tbl_d[$];
  vec_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int vec_no   = 0;

  function automatic vec_t mk(
    input logic cv_v, input logic [1:0] cmd_v, input logic bpe_v,
    input logic [7:0] bpa_v, input logic [7:0] pc_v, input logic clr_v,
    input logic en_v, input logic rdy_v, input logic run_v,
    input logic bp_v, input logic lim_v, input logic [15:0] cnt_v);
    vec_t v;
    v.cv = cv_v; v.cmd = cmd_v; v.bp_en = bpe_v; v.bp_addr = bpa_v;
    v.pc = pc_v; v.clr = clr_v;
    v.e_en = en_v; v.e_rdy = rdy_v; v.e_run = run_v;
    v.e_bp = bp_v; v.e_lim = lim_v; v.e_cnt = cnt_v;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic en, input logic rdy,
                            input logic run, input logic bp, input logic lim,
                            input logic [15:0] cnt);
    check({tag, ".cpu_en"},    32'(o_en),  32'(en));
    check({tag, ".cmd_ready"}, 32'(o_rdy), 32'(rdy));
    check({tag, ".running"},   32'(o_run), 32'(run));
    check({tag, ".bp_hit"},    32'(o_bp),  32'(bp));
    check({tag, ".limit_hit"}, 32'(o_lim), 32'(lim));
    check({tag, ".instr_cnt"}, 32'(o_cnt), 32'(cnt));
  endtask

  task automatic drive_idle();
    cv = 1'b0; cmd = C_NOP; bp_en = 1'b0; bp_addr = 8'h00; pc = 8'h00; clr = 1'b0;
  endtask

  // Drive one row just after the rising edge and queue its expectation.
  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    cv = v.cv; cmd = v.cmd; bp_en = v.bp_en; bp_addr = v.bp_addr;
    pc = v.pc; clr = v.clr;
    sb_q.push_back(v);
  endtask

  // Wait until the last queued row has been compared.
  task automatic drain();
    @(negedge clk);
    #1;
  endtask

  // Compare each queued row mid-cycle, away from the active edge.
  always @(negedge clk) begin : monitor
    vec_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_outs($sformatf("s%0d.vec%0d", sel, vec_no),
                 e.e_en, e.e_rdy, e.e_run, e.e_bp, e.e_lim, e.e_cnt);
      vec_no++;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    drive_idle();
    sel   = 0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_d = 1'b0;

    // ---- Config a: free run, breakpoint, halt-vs-breakpoint priority ----
    for (int k = 1; k <= 10; k++)
      tbl_a.push_back(mk(0, C_NOP, 0, 8'h00, 8'h00, 0, 1, 1, 1, 0, 0, 16'(k)));
    tbl_a.push_back(mk(1, C_HALT, 0, 8'h00, 8'h00, 1, 0, 1, 1, 0, 0, 16'd11));
    tbl_a.push_back(mk(1, C_RUN,  1, 8'h05, 8'h00, 0, 0, 1, 0, 0, 0, 16'd0));
    for (int p = 0; p <= 4; p++)
      tbl_a.push_back(mk(0, C_NOP, 1, 8'h05, 8'(p), 0, 1, 1, 1, 0, 0, 16'(p)));
    tbl_a.push_back(mk(0, C_NOP,  1, 8'h05, 8'h05, 0, 0, 1, 1, 0, 0, 16'd5));
    tbl_a.push_back(mk(0, C_NOP,  1, 8'h05, 8'h05, 0, 0, 1, 0, 1, 0, 16'd5));
    tbl_a.push_back(mk(1, C_RUN,  1, 8'h05, 8'h05, 0, 0, 1, 0, 1, 0, 16'd5));
    tbl_a.push_back(mk(0, C_NOP,  1, 8'h05, 8'h05, 0, 1, 1, 1, 0, 0, 16'd5));
    tbl_a.push_back(mk(0, C_NOP,  1, 8'h05, 8'h06, 0, 1, 1, 1, 0, 0, 16'd6));
    tbl_a.push_back(mk(0, C_NOP,  1, 8'h05, 8'h07, 0, 1, 1, 1, 0, 0, 16'd7));
    tbl_a.push_back(mk(1, C_STEP, 1, 8'h05, 8'h08, 0, 1, 1, 1, 0, 0, 16'd8));
    tbl_a.push_back(mk(1, C_HALT, 1, 8'h09, 8'h09, 0, 0, 1, 1, 0, 0, 16'd9));
    tbl_a.push_back(mk(0, C_NOP,  1, 8'h09, 8'h09, 0, 0, 1, 0, 0, 0, 16'd9));

    // ---- Config b: single steps, then the instruction limit ----
    tbl_b.push_back(mk(0, C_NOP,  0, 0, 0, 0, 0, 1, 0, 0, 0, 16'd0));
    tbl_b.push_back(mk(1, C_STEP, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'd0));
    tbl_b.push_back(mk(0, C_NOP,  0, 0, 0, 0, 1, 0, 0, 0, 0, 16'd0));
    tbl_b.push_back(mk(0, C_NOP,  0, 0, 0, 0, 0, 1, 0, 0, 0, 16'd1));
    tbl_b.push_back(mk(0, C_NOP,  0, 0, 0, 0, 0, 1, 0, 0, 0, 16'd1));
    tbl_b.push_back(mk(1, C_STEP, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'd1));
    tbl_b.push_back(mk(0, C_NOP,  0, 0, 0, 0, 1, 0, 0, 0, 0, 16'd1));
    tbl_b.push_back(mk(0, C_NOP,  0, 0, 0, 0, 0, 1, 0, 0, 0, 16'd2));
    tbl_b.push_back(mk(0, C_NOP,  0, 0, 0, 0, 0, 1, 0, 0, 0, 16'd2));
    tbl_b.push_back(mk(1, C_STEP, 0, 0, 0, 0, 0, 1, 0, 0, 0, 16'd2));
    tbl_b.push_back(mk(1, C_RUN,  0, 0, 0, 0, 1, 0, 0, 0, 0, 16'd2));
    tbl_b.push_back(mk(0, C_NOP,  0, 0, 0, 0, 0, 1, 0, 0, 0, 16'd3));
    tbl_b.push_back(mk(0, C_NOP,  0, 0, 0, 1, 0, 1, 0, 0, 0, 16'd3));
    tbl_b.push_back(mk(1, C_RUN,  0, 0, 0, 0, 0, 1, 0, 0, 0, 16'd0));
    for (int k = 0; k < 4; k++)
      tbl_b.push_back(mk(0, C_NOP, 0, 0, 0, 0, 1, 1, 1, 0, 0, 16'(k)));
    tbl_b.push_back(mk(0, C_NOP,  0, 0, 0, 0, 0, 1, 0, 0, 1, 16'd4));
    tbl_b.push_back(mk(1, C_RUN,  0, 0, 0, 0, 0, 1, 0, 0, 1, 16'd4));
    tbl_b.push_back(mk(0, C_NOP,  0, 0, 0, 0, 0, 1, 0, 0, 1, 16'd4));
    tbl_b.push_back(mk(1, C_STEP, 0, 0, 0, 0, 0, 1, 0, 0, 1, 16'd4));
    tbl_b.push_back(mk(0, C_NOP,  0, 0, 0, 0, 0, 1, 0, 0, 1, 16'd4));
    tbl_b.push_back(mk(0, C_NOP,  0, 0, 0, 1, 0, 1, 0, 0, 1, 16'd4));
    tbl_b.push_back(mk(1, C_RUN,  0, 0, 0, 0, 0, 1, 0, 0, 1, 16'd0));
    for (int k = 0; k < 4; k++)
      tbl_b.push_back(mk(0, C_NOP, 0, 0, 0, 0, 1, 1, 1, 0, 0, 16'(k)));
    tbl_b.push_back(mk(0, C_NOP,  0, 0, 0, 0, 0, 1, 0, 0, 1, 16'd4));

    // ---- Config d: 4-bit saturation, clear-vs-increment, resume ----
    for (int k = 1; k <= 20; k++)
      tbl_d.push_back(mk(0, C_NOP, 0, 0, 0, 0, 1, 1, 1, 0, 0, (k > 15) ? 16'd15 : 16'(k)));
    tbl_d.push_back(mk(0, C_NOP, 0, 8'h00, 8'h00, 1, 1, 1, 1, 0, 0, 16'd15));
    tbl_d.push_back(mk(0, C_NOP, 0, 8'h00, 8'h00, 0, 1, 1, 1, 0, 0, 16'd0));
    tbl_d.push_back(mk(0, C_NOP, 1, 8'h33, 8'h33, 0, 0, 1, 1, 0, 0, 16'd1));
    tbl_d.push_back(mk(1, C_RUN, 1, 8'h33, 8'h33, 0, 0, 1, 0, 1, 0, 16'd1));
    tbl_d.push_back(mk(0, C_NOP, 1, 8'h33, 8'h33, 0, 1, 1, 1, 0, 0, 16'd1));
    tbl_d.push_back(mk(0, C_NOP, 1, 8'h33, 8'h34, 0, 1, 1, 1, 0, 0, 16'd2));

    // Config a: reset state while held in reset, release at 100 ns.
    #50;
    check_outs("a_in_reset", 1, 1, 1, 0, 0, 16'd0);
    #50;
    rst_a = 1'b1;
    for (int i = 0; i < tbl_a.size(); i++) apply(tbl_a[i]);
    drain();

    // Config b: halted out of reset.
    rst_a = 1'b0;
    drive_idle();
    sel = 1;
    #1;
    check_outs("b_in_reset", 0, 1, 0, 0, 0, 16'd0);
    rst_b = 1'b1;
    for (int i = 0; i < tbl_b.size(); i++) apply(tbl_b[i]);
    drain();
    // Asynchronous reset clears the sticky limit flag and counter at once.
    rst_b = 1'b0;
    #1;
    check_outs("b_async_reset", 0, 1, 0, 0, 0, 16'd0);

    // Config d: saturating 4-bit counter.
    drive_idle();
    sel = 2;
    #1;
    check_outs("d_in_reset", 1, 1, 1, 0, 0, 16'd0);
    rst_d = 1'b1;
    for (int i = 0; i < tbl_d.size(); i++) apply(tbl_d[i]);
    drain();
    // Reset mid-RUN with a nonzero count: count drops immediately, and the
    // enable follows the free-running reset state.
    rst_d = 1'b0;
    #1;
    check_outs("d_async_reset", 1, 1, 1, 0, 0, 16'd0);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cpu15_run_ctrl
